// File: rtl/riscv_defs.sv
// Shared encodings for the core's memory path: access lengths, controller state,
// the capture tag carried through the read pipeline, and the IO window address bit.
package riscv_defs;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b11;

    localparam int IO_ADDR_BIT = 17;
    localparam int RD_LAT_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } mc_state_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } rd_tag_t;

    // 2'b10 is not a legal length; it is handled as a full word
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide external bus owner: arbitrates fetch vs data port and sequences each
// word access into pipelined little-endian byte transactions, honouring rdy_in.
module mem_ctrl
    import riscv_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [1:0]        dm_len_i,
    input  logic [31:0]       dm_wdata_i,
    output logic              dm_done_o,
    output logic [31:0]       dm_rdata_o,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic              busy_o
);

    mc_state_t         state;
    logic              sel_dm;
    logic              paused_q;
    logic              wr_q;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] mem_a_q;
    logic [2:0]        nbytes;
    logic [2:0]        iss_idx;
    logic [2:0]        cap_cnt;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_nxt;
    logic [7:0]        dout_q;
    rd_tag_t           rd_pipe [RD_LAT:0];
    logic              rd_resume;
    logic              last_cap;

    // On resume the oldest uncaptured byte goes straight onto the bus so the
    // restart costs no extra cycle beyond the read latency.
    assign rd_resume = paused_q && rdy_in && (state == ST_RD);
    assign mem_a     = rd_resume ? base + ADDR_W'(cap_cnt) : mem_a_q;
    assign mem_wr    = wr_q && rdy_in;
    assign mem_dout  = mem_wr ? dout_q : 8'h00;
    assign busy_o    = (state != ST_IDLE);

    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[8*rd_pipe[RD_LAT].idx +: 8] = mem_din;
        last_cap = rd_pipe[RD_LAT].vld && ({1'b0, rd_pipe[RD_LAT].idx} == nbytes - 3'd1);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= ST_IDLE;
            sel_dm     <= 1'b0;
            paused_q   <= 1'b0;
            wr_q       <= 1'b0;
            base       <= '0;
            mem_a_q    <= '0;
            nbytes     <= '0;
            iss_idx    <= '0;
            cap_cnt    <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            dout_q     <= '0;
            if_done_o  <= 1'b0;
            if_data_o  <= '0;
            dm_done_o  <= 1'b0;
            dm_rdata_o <= '0;
            for (int k = 0; k <= RD_LAT; k++) rd_pipe[k] <= '0;
        end else begin
            paused_q <= !rdy_in;
            if (rdy_in) begin
                if_done_o <= 1'b0;
                dm_done_o <= 1'b0;
                case (state)
                    // the done cycle is also an IDLE cycle but never grants
                    ST_IDLE: if (!if_done_o && !dm_done_o && (dm_req_i || if_req_i)) begin
                        sel_dm  <= dm_req_i;
                        base    <= dm_req_i ? dm_addr_i : if_addr_i;
                        mem_a_q <= dm_req_i ? dm_addr_i : if_addr_i;
                        nbytes  <= dm_req_i ? len_bytes(dm_len_i) : 3'd4;
                        wdata_q <= dm_wdata_i;
                        iss_idx <= 3'd1;
                        cap_cnt <= '0;
                        asm_q   <= '0;
                        if (dm_req_i && dm_we_i) begin
                            state  <= ST_WR;
                            wr_q   <= 1'b1;
                            dout_q <= dm_wdata_i[7:0];
                        end else begin
                            state      <= ST_RD;
                            rd_pipe[0] <= '{1'b1, 2'd0};
                        end
                    end
                    ST_RD: begin
                        if (rd_resume) begin
                            for (int k = 0; k <= RD_LAT; k++) rd_pipe[k] <= '0;
                            rd_pipe[1] <= '{1'b1, cap_cnt[1:0]};
                            if (cap_cnt + 3'd1 < nbytes) begin
                                mem_a_q    <= base + ADDR_W'(cap_cnt + 3'd1);
                                rd_pipe[0] <= '{1'b1, 2'(cap_cnt + 3'd1)};
                                iss_idx    <= cap_cnt + 3'd2;
                            end else begin
                                mem_a_q <= base + ADDR_W'(cap_cnt);
                                iss_idx <= cap_cnt + 3'd1;
                            end
                        end else begin
                            for (int k = 1; k <= RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
                            rd_pipe[0] <= '0;
                            if (iss_idx < nbytes) begin
                                mem_a_q    <= base + ADDR_W'(iss_idx);
                                rd_pipe[0] <= '{1'b1, iss_idx[1:0]};
                                iss_idx    <= iss_idx + 3'd1;
                            end
                            if (rd_pipe[RD_LAT].vld) begin
                                asm_q   <= asm_nxt;
                                cap_cnt <= cap_cnt + 3'd1;
                            end
                            if (last_cap) begin
                                state <= ST_IDLE;
                                if (sel_dm) begin
                                    dm_done_o  <= 1'b1;
                                    dm_rdata_o <= asm_nxt;
                                end else begin
                                    if_done_o <= 1'b1;
                                    if_data_o <= asm_nxt;
                                end
                            end
                        end
                    end
                    // a paused write byte stays on the bus and is rewritten on resume
                    ST_WR: begin
                        if (iss_idx < nbytes) begin
                            mem_a_q <= base + ADDR_W'(iss_idx);
                            dout_q  <= wdata_q[8*iss_idx +: 8];
                            iss_idx <= iss_idx + 3'd1;
                        end else begin
                            wr_q      <= 1'b0;
                            dout_q    <= '0;
                            dm_done_o <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed bus scenarios plus random traffic against a
// shadow-memory reference with spec-derived latency bounds.
module tb_mem_ctrl;
    import riscv_defs::*;

    localparam int RL = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [1:0]  dm_len_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic        dm_done_o;
    logic [31:0] dm_rdata_o;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        busy_o;

    mem_ctrl #(.ADDR_W(32), .RD_LAT(RL)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_data_o(if_data_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_len_i(dm_len_i),
        .dm_wdata_i(dm_wdata_i), .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .busy_o(busy_o)
    );

    always #5 clk_in = ~clk_in;

    // external RAM: 4 KiB aliased, read data appears RL cycles after the address
    logic [7:0]  ram       [0:4095];
    logic [7:0]  model_ram [0:4095];
    logic [31:0] a_d1 = '0, a_d2 = '0;
    always @(posedge clk_in) begin
        a_d1 <= mem_a;
        a_d2 <= a_d1;
        if (mem_wr) ram[mem_a[11:0]] = mem_dout;
    end
    assign mem_din = ram[a_d2[11:0]];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
        ram[a[11:0]] = v;
        model_ram[a[11:0]] = v;
    endtask

    task automatic run_txn(input bit dm, input bit we, input logic [31:0] addr,
                           input logic [1:0] len, input logic [31:0] wd,
                           input int p, input int plen, input bit trace,
                           output logic [31:0] res_a);
        int n, nom, done_cyc, ndone, nother, wr_seen;
        bit st;
        logic [31:0] want, got, ai;
        st  = dm && we;
        n   = !dm ? 4 : (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        nom = st ? n + 1 : n + 3;
        want = '0; got = '0; res_a = '0;
        for (int i = 0; i < n; i++) begin
            ai = addr + 32'(i);
            if (st) model_ram[ai[11:0]] = wd[8*i +: 8];
            else    want[8*i +: 8] = model_ram[ai[11:0]];
        end
        done_cyc = -1; ndone = 0; nother = 0; wr_seen = 0;
        @(negedge clk_in);
        if (dm) begin
            dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_len_i = len; dm_wdata_i = wd;
        end else begin
            if_req_i = 1'b1; if_addr_i = addr;
        end
        for (int c = 1; c <= 48; c++) begin
            @(negedge clk_in);
            rdy_in = !(plen > 0 && c >= p && c < p + plen);
            #1;
            if (c == 1) chk("busy", busy_o, 1);
            if (plen > 0 && c == p + plen) res_a = mem_a;
            if (!rdy_in) chk("pause_wr", mem_wr, 0);
            if (mem_wr) wr_seen++;
            if (trace && (plen == 0 || c < p) && c < nom) begin
                if (c <= n) begin
                    chk("addr", mem_a, addr + 32'(c - 1));
                    chk("wr", mem_wr, st);
                    if (st) chk("dout", mem_dout, wd[8*(c-1) +: 8]);
                end else begin
                    chk("addr_hold", mem_a, addr + 32'(n - 1));
                    chk("wr_idle", mem_wr, 0);
                    chk("dout_idle", mem_dout, 0);
                end
            end
            if (dm ? if_done_o : dm_done_o) nother++;
            if (dm ? dm_done_o : if_done_o) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    got = dm ? dm_rdata_o : if_data_o;
                    chk("busy_done", busy_o, 0);
                end
                dm_req_i = 1'b0; if_req_i = 1'b0;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        rdy_in = 1'b1; dm_req_i = 1'b0; if_req_i = 1'b0;
        chk("ndone", ndone, 1);
        chk("nother", nother, 0);
        if (plen == 0 || st) chk("lat", done_cyc, nom + plen);
        else chk("lat_rng", (done_cyc >= nom + plen && done_cyc <= nom + plen + RL), 1);
        if (st) begin
            for (int i = 0; i < n; i++) begin
                ai = addr + 32'(i);
                chk("ram", ram[ai[11:0]], model_ram[ai[11:0]]);
            end
        end else begin
            chk("data", got, want);
            chk("rd_nowr", wr_seen, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, addr, wd;
        logic [1:0]  len;
        bit          dm, we;
        int          n, p, plen, dmd, ifd, ndm, nif;

        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'($urandom);
            model_ram[i] = ram[i];
        end

        // reset state
        #1;
        chk("rst_if_done", if_done_o, 0);
        chk("rst_if_data", if_data_o, 0);
        chk("rst_dm_done", dm_done_o, 0);
        chk("rst_dm_rdata", dm_rdata_o, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_busy", busy_o, 0);
        @(negedge clk_in); rst_in = 1'b0;
        @(negedge clk_in);

        // instruction fetch
        set_byte(32'h100, 8'h13); set_byte(32'h101, 8'h05);
        set_byte(32'h102, 8'h00); set_byte(32'h103, 8'h00);
        run_txn(0, 0, 32'h100, 2'b11, 0, 0, 0, 1, ra);
        chk("if_data_const", if_data_o, 32'h0000_0513);

        // word store
        run_txn(1, 1, 32'h200, 2'b11, 32'hDEAD_BEEF, 0, 0, 1, ra);

        // simultaneous requests: data port first, fetch granted the cycle after
        set_byte(32'h040, 8'h5A); set_byte(32'h041, 8'hC3);
        @(negedge clk_in);
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h40; dm_len_i = 2'b01;
        if_req_i = 1; if_addr_i = 32'h80;
        dmd = -1; ifd = -1; ndm = 0; nif = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_in); #1;
            if (dmd > 0 && c == dmd + 2) chk("if_after_dm_addr", mem_a, 32'h80);
            if (dm_done_o) begin ndm++; if (dmd < 0) dmd = c; dm_req_i = 0; end
            if (if_done_o) begin nif++; if (ifd < 0) ifd = c; if_req_i = 0; end
            if (ifd > 0 && c >= ifd + 2) break;
        end
        dm_req_i = 0; if_req_i = 0;
        chk("arb_dm_cyc", dmd, 5);
        chk("arb_if_cyc", ifd, 13);
        chk("arb_ndm", ndm, 1);
        chk("arb_nif", nif, 1);
        chk("arb_dm_data", dm_rdata_o, 32'h0000_C35A);
        chk("arb_if_data", if_data_o,
            {model_ram[12'h083], model_ram[12'h082], model_ram[12'h081], model_ram[12'h080]});

        // byte load from the IO window
        set_byte(32'h30000, 8'h41);
        run_txn(1, 0, 32'h30000, 2'b00, 0, 0, 0, 1, ra);
        chk("lb_const", dm_rdata_o, 32'h0000_0041);

        // pause during a fetch: the second byte is put back on the bus at resume
        run_txn(0, 0, 32'h500, 2'b11, 0, 4, 3, 1, ra);
        chk("resume_addr", ra, 32'h501);

        // reset in the middle of a store
        @(negedge clk_in);
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h300; dm_len_i = 2'b11; dm_wdata_i = 32'h1122_3344;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("arst_mem_wr", mem_wr, 0);
        chk("arst_mem_a", mem_a, 0);
        chk("arst_mem_dout", mem_dout, 0);
        chk("arst_busy", busy_o, 0);
        dm_req_i = 0;
        ndm = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in); #1;
            if (dm_done_o) ndm++;
        end
        chk("arst_no_done", ndm, 0);
        rst_in = 1'b0;
        @(negedge clk_in);
        run_txn(1, 1, 32'h300, 2'b11, 32'hCAFE_F00D, 0, 0, 1, ra);
        run_txn(1, 0, 32'h300, 2'b11, 0, 0, 0, 1, ra);
        chk("post_rst_rd", dm_rdata_o, 32'hCAFE_F00D);

        // address wrap across 2^32
        run_txn(1, 1, 32'hFFFF_FFFE, 2'b11, 32'hA1B2_C3D4, 0, 0, 1, ra);
        run_txn(0, 0, 32'hFFFF_FFFE, 2'b11, 0, 0, 0, 1, ra);

        // random traffic with occasional pauses
        for (int t = 0; t < 40; t++) begin
            dm   = 1'($urandom);
            we   = dm & 1'($urandom);
            len  = 2'($urandom);
            addr = $urandom;
            if (t % 5 == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            wd   = $urandom;
            n    = !dm ? 4 : (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
            p    = 0;
            plen = 0;
            if ($urandom_range(0, 2) == 0) begin
                p    = $urandom_range(1, we ? n : n + 2);
                plen = $urandom_range(1, 4);
            end
            run_txn(dm, we, addr, len, wd, p, plen, (plen == 0), ra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
